cnn_cell_engine: RTL and testbench
==================================

# cnn_cell_engine

Sequential, parametrised cellular-neural-network cell update engine. It computes one cell's state sum, sum(A·Y) + sum(B·U) + I, over a K×K neighbourhood using a single time-multiplexed multiply-accumulate. It optionally applies the standard piecewise-linear CNN output clamp. It sits between the neighbourhood window buffer (upstream) and the state/output memory writer (downstream), with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 16: signed operand width, fixed point Q(WIDTH-FRAC).FRAC
- `FRAC`, 8: fractional bits; legal range 0..WIDTH-1
- `K`, 3: neighbourhood side; legal values are odd, 1..7
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: operand set valid
- `in_ready` out 1: engine can accept an operand set
- `ctrl_only` in 1: sampled at accept; 1 = feed-forward mode, only B·U + I is computed
- `nl_en` in 1: sampled at accept; 1 = clamp `out_y` to [-1.0, +1.0]
- `a_flat`, `b_flat`, `y_flat`, `u_flat` in K·K·WIDTH: signed templates and neighbourhood values, tap i at bits [i·WIDTH +: WIDTH]
- `bias` in WIDTH: signed I, Q.FRAC
- `out_valid` out 1: result valid
- `out_ready` in 1: downstream accepts the result
- `out_acc` out ACC_W: raw accumulator, Q.(2·FRAC), ACC_W = 2·WIDTH + clog2(2·K·K+1)
- `out_y` out WIDTH: scaled, saturated and optionally clamped result, Q.FRAC
- `busy` out 1: high in RUN and DONE

## Operation
- **Reset values:** all outputs are 0 while `rst` is high. This includes `in_ready`, `out_valid`, `out_acc`, `out_y` and `busy`. `in_ready` goes to 1 in the first cycle after `rst` falls.
- **FSM:** IDLE → RUN → FIN → DONE → IDLE.
  - **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready`, the engine registers all operands, `ctrl_only` and `nl_en`. It sets acc = sign-extended `bias` << FRAC and tap index = 0, then moves to RUN.
  - **RUN:** one product is added per cycle. With `ctrl_only`=0 there are N = 2·K·K taps: A[i]·Y[i] for i = 0..K·K-1, then B[i]·U[i]. With `ctrl_only`=1 there are N = K·K taps, B·U only. After the last tap the FSM moves to FIN.
  - **FIN:** computes `out_y` and registers both outputs. Moves to DONE.
  - **DONE:** `out_valid`=1. `out_acc` and `out_y` are held stable until `out_valid`&&`out_ready`, then the FSM returns to IDLE.
- **Arithmetic:**
  - Products are full 2·WIDTH signed.
  - ACC_W is sized so the accumulator never overflows for any inputs. The result is therefore order-independent and exact.
  - `out_y` = acc >>> FRAC (arithmetic shift, rounds toward −∞), saturated to the signed WIDTH range [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - If `nl_en` is set, the saturated value is then clamped to [−2^FRAC, +2^FRAC]. When FRAC = WIDTH-1, +2^FRAC is unrepresentable, so the upper bound becomes 2^(WIDTH-1)−1.
- **Input changes:** changes on the operand inputs after accept have no effect on the operation in flight.
- **`in_valid` while busy:** ignored. Nothing is queued and `in_ready` stays 0.
- **Reset mid-operation:** the FSM aborts to the reset state, the partial result is discarded and no `out_valid` pulse is produced.

## Timing
- The accept handshake occurs in cycle 0.
- RUN occupies cycles 1..N, FIN is cycle N+1, and `out_valid` is first high in cycle N+2.
- With K=3, FRAC=8: full mode gives `out_valid` at cycle 20; `ctrl_only` gives cycle 11.
- The output handshake in cycle T returns the engine to IDLE. `in_ready`=1 in T+1.
- No overlap between operations. Maximum throughput is one result per N+3 cycles.
- `busy` is 1 from cycle 1 through the output handshake cycle.

## Structure
- **Package `cnn_pkg`:**
  - state enum {IDLE, RUN, FIN, DONE}
  - function `acc_width(WIDTH, K)`
  - function `sat_clamp` (shift, saturate and optional clamp), shared with future array-level blocks
- **Sub-module `cnn_mac_unit`:**
  - operand mux input, signed WIDTH×WIDTH multiplier, ACC_W accumulator register
  - `load` (acc ← init) and `en` (acc += product) controls
- **Top level:** FSM, tap counter (clog2(2·K·K) bits) and operand capture registers.

## Test plan
1. **Full mode, nl_en=0:** K=3, all A=Y=256, B=U=0, bias=0 → `out_acc`=589824, `out_y`=2304, `out_valid` at cycle 20. Rerun with nl_en=1 → `out_y`=256.
2. **ctrl_only=1:** B[4]=512, U[4]=−384, other B/U=0, all A/Y=1000, bias=64 → `out_acc`=−180224, `out_y`=−704, `out_valid` at cycle 11. Rerun with nl_en=1 → `out_y`=−256.
3. **Saturation:** all A=Y=B=U=32767 → `out_y`=32767. All A,B=−32768 and Y,U=32767 → `out_y`=−32768. `out_acc` exact in both cases.
4. **Backpressure:** `out_ready`=0 for 6 cycles after `out_valid` → `out_valid`/`out_y` held and `in_ready`=0. A new `in_valid` during this window is ignored. Release `out_ready` → `in_ready`=1 the next cycle and the next result is correct.
5. **Reset mid-RUN:** assert `rst` in cycle 5 → no `out_valid`, all outputs 0. `in_ready`=1 in the cycle after `rst` falls; a subsequent scenario-1 operation gives 589824.
6. **Back-to-back:** drive `in_valid` continuously with `out_ready`=1 → accepts every N+3 cycles. Operand changes mid-operation do not affect that operation's result.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the CNN cell update engines.
package cnn_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

  // Upper bounds that let sat_clamp serve any legal WIDTH/K combination.
  localparam int unsigned MaxWidth = 32;
  localparam int unsigned MaxAccW  = 2 * MaxWidth + 8;

  typedef logic signed [MaxAccW-1:0]  wide_acc_t;
  typedef logic signed [MaxWidth-1:0] wide_y_t;

  function automatic int unsigned acc_width(int unsigned width, int unsigned k);
    return 2 * width + $clog2(2 * k * k + 1);
  endfunction

  // Q.(2*frac) accumulator -> Q.frac result: floor shift, saturate, optional [-1, +1] clamp.
  function automatic wide_y_t sat_clamp(wide_acc_t acc, int unsigned width, int unsigned frac,
                                        logic nl_en);
    wide_acc_t val;
    wide_acc_t hi;
    wide_acc_t lo;
    val = acc >>> frac;
    hi  = (wide_acc_t'(1) <<< (width - 1)) - wide_acc_t'(1);
    lo  = -(wide_acc_t'(1) <<< (width - 1));
    if (val > hi) begin
      val = hi;
    end else if (val < lo) begin
      val = lo;
    end
    if (nl_en) begin
      // +1.0 does not fit when all non-sign bits are fractional
      if (frac != width - 1) begin
        hi = wide_acc_t'(1) <<< frac;
      end
      lo = -(wide_acc_t'(1) <<< frac);
      if (val > hi) begin
        val = hi;
      end else if (val < lo) begin
        val = lo;
      end
    end
    return wide_y_t'(val);
  endfunction

endpackage

// File: rtl/cnn_mac_unit.sv
// Time-multiplexed signed multiply-accumulate with A/Y versus B/U operand select.
module cnn_mac_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = 37
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    en,
  input  logic                    sel_b,
  input  logic signed [WIDTH-1:0] a_tap,
  input  logic signed [WIDTH-1:0] y_tap,
  input  logic signed [WIDTH-1:0] b_tap,
  input  logic signed [WIDTH-1:0] u_tap,
  input  logic signed [ACC_W-1:0] init,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [WIDTH-1:0]   op_w;
  logic signed [WIDTH-1:0]   op_x;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;

  always_comb begin
    op_w = sel_b ? b_tap : a_tap;
    op_x = sel_b ? u_tap : y_tap;
    prod = (2 * WIDTH)'(op_w) * (2 * WIDTH)'(op_x);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= init;
    end else if (en) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/cnn_cell_engine.sv
// CNN cell state engine: captures one K*K neighbourhood, accumulates A*Y + B*U + I serially.
module cnn_cell_engine
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned K     = 3,
  localparam int unsigned ACC_W = acc_width(WIDTH, K)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      ctrl_only,
  input  logic                      nl_en,
  input  logic [K*K*WIDTH-1:0]      a_flat,
  input  logic [K*K*WIDTH-1:0]      b_flat,
  input  logic [K*K*WIDTH-1:0]      y_flat,
  input  logic [K*K*WIDTH-1:0]      u_flat,
  input  logic signed [WIDTH-1:0]   bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACC_W-1:0]   out_acc,
  output logic signed [WIDTH-1:0]   out_y,
  output logic                      busy
);

  localparam int unsigned KK    = K * K;
  localparam int unsigned CntW  = $clog2(2 * KK);
  localparam int unsigned FlatW = KK * WIDTH;

  state_e                  state_q;
  logic [FlatW-1:0]        a_q, b_q, y_q, u_q;
  logic                    ctrl_q, nl_q;
  logic [CntW-1:0]         idx_q;
  logic signed [ACC_W-1:0] out_acc_q;
  logic signed [WIDTH-1:0] out_y_q;

  logic                    accept, sel_b, last_tap;
  logic [CntW-1:0]         tap;
  int unsigned             base;
  logic signed [WIDTH-1:0] a_tap, y_tap, b_tap, u_tap;
  logic signed [ACC_W-1:0] init, acc;

  assign accept = in_valid && in_ready;
  assign init   = ACC_W'(bias) <<< FRAC;

  // Taps 0..KK-1 walk A/Y, KK..2KK-1 walk B/U; feed-forward mode walks B/U from tap 0.
  always_comb begin
    sel_b    = ctrl_q || (idx_q >= CntW'(KK));
    tap      = (sel_b && !ctrl_q) ? idx_q - CntW'(KK) : idx_q;
    last_tap = idx_q == (ctrl_q ? CntW'(KK - 1) : CntW'(2 * KK - 1));
    base     = 32'(tap) * WIDTH;
    a_tap    = a_q[base +: WIDTH];
    y_tap    = y_q[base +: WIDTH];
    b_tap    = b_q[base +: WIDTH];
    u_tap    = u_q[base +: WIDTH];
  end

  cnn_mac_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .en    (state_q == StRun),
    .sel_b (sel_b),
    .a_tap (a_tap),
    .y_tap (y_tap),
    .b_tap (b_tap),
    .u_tap (u_tap),
    .init  (init),
    .acc   (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ctrl_q    <= 1'b0;
      nl_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
      u_q       <= '0;
      out_acc_q <= '0;
      out_y_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a_flat;
            b_q     <= b_flat;
            y_q     <= y_flat;
            u_q     <= u_flat;
            ctrl_q  <= ctrl_only;
            nl_q    <= nl_en;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          idx_q <= idx_q + CntW'(1);
          if (last_tap) state_q <= StFin;
        end
        StFin: begin
          out_acc_q <= acc;
          out_y_q   <= WIDTH'(sat_clamp(wide_acc_t'(acc), WIDTH, FRAC, nl_q));
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs read zero for the whole time reset is asserted, not just after its first edge.
  always_comb begin
    in_ready  = !rst && (state_q == StIdle);
    busy      = !rst && (state_q != StIdle);
    out_valid = !rst && (state_q == StDone);
    out_acc   = rst ? '0 : out_acc_q;
    out_y     = rst ? '0 : out_y_q;
  end

endmodule

// File: tb/tb_cnn_cell_engine.sv
// Directed self-checking bench for cnn_cell_engine (K=3, WIDTH=16, FRAC=8).
module tb_cnn_cell_engine;
  import cnn_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned K     = 3;
  localparam int unsigned KK    = K * K;
  localparam int unsigned ACC_W = acc_width(WIDTH, K);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic                    ctrl_only = 1'b0;
  logic                    nl_en = 1'b0;
  logic [KK*WIDTH-1:0]     a_flat = '0, b_flat = '0, y_flat = '0, u_flat = '0;
  logic signed [WIDTH-1:0] bias = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic signed [ACC_W-1:0] out_acc;
  logic signed [WIDTH-1:0] out_y;
  logic                    busy;

  int     n_checks = 0;
  int     n_errors = 0;
  longint cycle = 0;

  cnn_cell_engine #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .K     (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_only (ctrl_only),
    .nl_en     (nl_en),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .y_flat    (y_flat),
    .u_flat    (u_flat),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_y     (out_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int va, input int vy, input int vb, input int vu);
    for (int i = 0; i < int'(KK); i++) begin
      a_flat[i*WIDTH +: WIDTH] = WIDTH'(va);
      y_flat[i*WIDTH +: WIDTH] = WIDTH'(vy);
      b_flat[i*WIDTH +: WIDTH] = WIDTH'(vb);
      u_flat[i*WIDTH +: WIDTH] = WIDTH'(vu);
    end
  endtask

  task automatic set_bu(input int i, input int vb, input int vu);
    b_flat[i*WIDTH +: WIDTH] = WIDTH'(vb);
    u_flat[i*WIDTH +: WIDTH] = WIDTH'(vu);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, ".valid"}, out_valid, 1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check({tag, ".ready"}, in_ready, 1);
  endtask

  // Accept one operand set (engine idle, out_ready=1), check latency, result and return to idle.
  task automatic do_op(input string tag, input logic ctrl, input logic nl, input longint eacc,
                       input longint ey, input int elat);
    int c;
    ctrl_only = ctrl;
    nl_en     = nl;
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".busy"}, busy, 1);
    wait_valid(tag, c);
    check({tag, ".latency"}, c + 1, elat);
    check({tag, ".acc"}, out_acc, eacc);
    check({tag, ".y"}, out_y, ey);
    tick();
    check({tag, ".idle_ready"}, in_ready, 1);
    check({tag, ".idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int     c, seen;
    longint t0, t1, t2;

    // Reset state
    repeat (3) tick();
    check("rst.in_ready", in_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_acc", out_acc, 0);
    check("rst.out_y", out_y, 0);
    rst = 1'b0;
    tick();
    check("rst.release_ready", in_ready, 1);

    // Full mode, then with clamp
    set_all(256, 256, 0, 0);
    bias = 0;
    do_op("full", 1'b0, 1'b0, 589824, 2304, 20);
    do_op("full_nl", 1'b0, 1'b1, 589824, 256, 20);

    // Feed-forward mode; A/Y must be ignored
    set_all(1000, 1000, 0, 0);
    set_bu(4, 512, -384);
    bias = 64;
    do_op("ctrl", 1'b1, 1'b0, -180224, -704, 11);
    do_op("ctrl_nl", 1'b1, 1'b1, -180224, -256, 11);

    // Shift rounds toward minus infinity
    set_all(0, 0, 0, 0);
    set_bu(0, 1, -1);
    bias = 0;
    do_op("floor", 1'b1, 1'b0, -1, -1, 11);

    // Saturation at both rails, accumulator exact
    set_all(32767, 32767, 32767, 32767);
    do_op("sat_pos", 1'b0, 1'b0, 64'sd19326173202, 32767, 20);
    set_all(-32768, 32767, -32768, 32767);
    do_op("sat_neg", 1'b0, 1'b0, -64'sd19326763008, -32768, 20);

    // Backpressure: result held, competing request ignored
    set_all(256, 256, 0, 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ctrl_only = 1'b0;
    nl_en     = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid("bp", c);
    for (int i = 0; i < 6; i++) begin
      set_all(100, 100, 100, 100);
      in_valid = 1'b1;
      check("bp.hold_valid", out_valid, 1);
      check("bp.hold_y", out_y, 2304);
      check("bp.in_ready", in_ready, 0);
      tick();
    end
    check("bp.hold_acc", out_acc, 589824);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp.release_ready", in_ready, 1);
    check("bp.release_valid", out_valid, 0);
    do_op("bp.next", 1'b0, 1'b0, 180000, 703, 20);

    // Reset in cycle 5 of a run
    set_all(256, 256, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.acc", out_acc, 0);
    repeat (2) tick();
    check("rstmid.out_valid", out_valid, 0);
    check("rstmid.in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    check("rstmid.release_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rstmid.no_valid", seen, 0);
    do_op("rstmid.rerun", 1'b0, 1'b0, 589824, 2304, 20);

    // Back-to-back with operands changing mid-flight
    set_all(256, 256, 0, 0);
    in_valid = 1'b1;
    wait_ready("b2b.0");
    tick();
    t0 = cycle;
    set_all(512, 512, 0, 0);
    wait_valid("b2b.0", c);
    check("b2b.0.acc", out_acc, 589824);
    check("b2b.0.y", out_y, 2304);
    wait_ready("b2b.1");
    tick();
    t1 = cycle;
    check("b2b.gap1", t1 - t0, 21);
    set_all(0, 0, 0, 0);
    wait_valid("b2b.1", c);
    check("b2b.1.acc", out_acc, 2359296);
    check("b2b.1.y", out_y, 9216);
    wait_ready("b2b.2");
    tick();
    t2 = cycle;
    check("b2b.gap2", t2 - t1, 21);
    in_valid = 1'b0;
    wait_valid("b2b.2", c);
    check("b2b.2.acc", out_acc, 0);
    tick();
    check("b2b.idle", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
